// File: rtl/alb_mw_ctrl_if.sv
// Request/result and ALB-slice signal bundle for the multi-word ALB sequencer.
// master = environment (requester + ALB), slave = alb_mw_ctrl.
interface alb_mw_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 4
);
  localparam int OW = DATA_WIDTH * NUM_WORDS;

  logic                  start;
  logic                  ready;
  logic [1:0]            op;
  logic [OW-1:0]         opa;
  logic [OW-1:0]         opb;
  logic                  cin;

  logic [DATA_WIDTH-1:0] alb_a;
  logic [DATA_WIDTH-1:0] alb_b;
  logic                  alb_ci;
  logic [1:0]            alb_i;
  logic [DATA_WIDTH-1:0] alb_f;
  logic                  alb_co;
  logic                  alb_vo;
  logic                  alb_no;
  logic                  alb_zo;

  logic [OW-1:0]         res;
  logic                  res_co;
  logic                  res_vo;
  logic                  res_no;
  logic                  res_zo;
  logic                  res_valid;
  logic                  res_ready;

  modport master (
    output start, op, opa, opb, cin, res_ready,
    output alb_f, alb_co, alb_vo, alb_no, alb_zo,
    input  ready, alb_a, alb_b, alb_ci, alb_i,
    input  res, res_co, res_vo, res_no, res_zo, res_valid
  );

  modport slave (
    input  start, op, opa, opb, cin, res_ready,
    input  alb_f, alb_co, alb_vo, alb_no, alb_zo,
    output ready, alb_a, alb_b, alb_ci, alb_i,
    output res, res_co, res_vo, res_no, res_zo, res_valid
  );
endinterface

// File: rtl/alb_mw_ctrl.sv
// Multi-word sequencer for a DATA_WIDTH-bit ALB: feeds operand slices low word
// first, chains the carry, and reassembles the full-width result and flags.
module alb_mw_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 4
) (
  input  logic         clk,
  input  logic         reset,
  alb_mw_ctrl_if.slave bus
);
  localparam int OW = DATA_WIDTH * NUM_WORDS;
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [1:0]      op_q, op_d;
  logic [OW-1:0]   opa_q, opa_d;
  logic [OW-1:0]   opb_q, opb_d;
  logic            cin_q, cin_d;
  logic [OW-1:0]   res_q, res_d;
  logic            co_q, co_d;
  logic            vo_q, vo_d;
  logic            no_q, no_d;
  logic            zo_q, zo_d;
  logic [1:0]      alb_i_q, alb_i_d;

  logic                  arith_s;
  logic                  last_s;
  logic [DATA_WIDTH-1:0] alb_a_s;
  logic [DATA_WIDTH-1:0] alb_b_s;
  logic                  alb_ci_s;

  function automatic logic [DATA_WIDTH-1:0] word_of(input logic [OW-1:0] v, input int k);
    return v[k*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // ops 01 and 11 are the carry-chained ones; 00 and 10 are bitwise
  assign arith_s = op_q[0];
  assign last_s  = (state_q == RUN) && (idx_q == LAST_IDX);

  // Next-state and datapath capture
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cin_d   = cin_q;
    res_d   = res_q;
    co_d    = co_q;
    vo_d    = vo_q;
    no_d    = no_q;
    zo_d    = zo_q;
    alb_i_d = alb_i_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          opa_d   = bus.opa;
          opb_d   = bus.opb;
          cin_d   = bus.cin;
          alb_i_d = bus.op;
          idx_d   = {IW{1'b0}};
          res_d   = {OW{1'b0}};
          co_d    = 1'b0;
          vo_d    = 1'b0;
          no_d    = 1'b0;
          zo_d    = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = RUN;
      end
      RUN: begin
        res_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = bus.alb_f;
        zo_d = zo_q & bus.alb_zo;
        if (last_s) begin
          // carry/overflow of a bitwise op carry no meaning and are forced low
          co_d  = arith_s & bus.alb_co;
          vo_d  = arith_s & bus.alb_vo;
          no_d  = bus.alb_no;
          idx_d = {IW{1'b0}};
          if (bus.res_ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end else begin
          idx_d   = idx_q + {{(IW-1){1'b0}}, 1'b1};
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slice drive towards the ALB; the carry is passed straight through in RUN
  always_comb begin
    alb_a_s  = {DATA_WIDTH{1'b0}};
    alb_b_s  = {DATA_WIDTH{1'b0}};
    alb_ci_s = 1'b0;
    case (state_q)
      ISSUE: begin
        alb_a_s  = word_of(opa_q, 0);
        alb_b_s  = word_of(opb_q, 0);
        alb_ci_s = arith_s & cin_q;
      end
      RUN: begin
        if (!last_s) begin
          alb_a_s  = word_of(opa_q, int'(idx_q) + 1);
          alb_b_s  = word_of(opb_q, int'(idx_q) + 1);
          alb_ci_s = arith_s & bus.alb_co;
        end else begin
          alb_a_s  = {DATA_WIDTH{1'b0}};
          alb_b_s  = {DATA_WIDTH{1'b0}};
          alb_ci_s = 1'b0;
        end
      end
      default: begin
        alb_a_s  = {DATA_WIDTH{1'b0}};
        alb_b_s  = {DATA_WIDTH{1'b0}};
        alb_ci_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= {IW{1'b0}};
      op_q    <= 2'b00;
      opa_q   <= {OW{1'b0}};
      opb_q   <= {OW{1'b0}};
      cin_q   <= 1'b0;
      res_q   <= {OW{1'b0}};
      co_q    <= 1'b0;
      vo_q    <= 1'b0;
      no_q    <= 1'b0;
      zo_q    <= 1'b0;
      alb_i_q <= 2'b00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      co_q    <= co_d;
      vo_q    <= vo_d;
      no_q    <= no_d;
      zo_q    <= zo_d;
      alb_i_q <= alb_i_d;
    end
  end

  // The last slice is presented live in its own cycle so the result appears
  // NUM_WORDS cycles after accept; DONE then replays the captured copy.
  assign bus.ready     = (state_q == IDLE);
  assign bus.res_valid = last_s || (state_q == DONE);
  assign bus.res       = last_s ? res_d : res_q;
  assign bus.res_co    = last_s ? co_d  : co_q;
  assign bus.res_vo    = last_s ? vo_d  : vo_q;
  assign bus.res_no    = last_s ? no_d  : no_q;
  assign bus.res_zo    = last_s ? zo_d  : zo_q;
  assign bus.alb_a     = alb_a_s;
  assign bus.alb_b     = alb_b_s;
  assign bus.alb_ci    = alb_ci_s;
  assign bus.alb_i     = alb_i_q;

endmodule

// File: tb/tb_alb_mw_ctrl.sv
// Directed-vector bench for alb_mw_ctrl at the default 4 x 8-bit geometry,
// with a behavioural registered-input ALB slice model.
module tb_alb_mw_ctrl;
  localparam int DW = 8;
  localparam int NW = 4;
  localparam int OW = DW * NW;
  localparam int NV = 11;

  typedef struct {
    logic [1:0]    op;
    logic [OW-1:0] opb;
    logic [OW-1:0] opa;
    logic          cin;
    logic [OW-1:0] res;
    logic          co;
    logic          vo;
    logic          no;
    logic          zo;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vecs[NV];

  alb_mw_ctrl_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) bus ();

  alb_mw_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALB slice model: operands and carry registered, opcode combinational.
  // Bitwise ops report co/vo high so any leak into the result flags shows.
  logic [DW-1:0] m_a_q, m_b_q;
  logic          m_ci_q;
  logic [DW:0]   m_sum;
  logic [DW-1:0] m_f;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_a_q  <= '0;
      m_b_q  <= '0;
      m_ci_q <= 1'b0;
    end else begin
      m_a_q  <= bus.alb_a;
      m_b_q  <= bus.alb_b;
      m_ci_q <= bus.alb_ci;
    end
  end

  always_comb begin
    m_sum      = '0;
    m_f        = '0;
    bus.alb_co = 1'b0;
    bus.alb_vo = 1'b0;
    case (bus.alb_i)
      2'b00: begin
        m_f = m_b_q | m_a_q;
        bus.alb_co = 1'b1;
        bus.alb_vo = 1'b1;
      end
      2'b01: begin
        m_sum = {1'b0, m_b_q} + {1'b0, m_a_q} + {{DW{1'b0}}, m_ci_q};
        m_f = m_sum[DW-1:0];
        bus.alb_co = m_sum[DW];
        bus.alb_vo = (m_b_q[DW-1] == m_a_q[DW-1]) && (m_f[DW-1] != m_b_q[DW-1]);
      end
      2'b10: begin
        m_f = ~m_b_q & m_a_q;
        bus.alb_co = 1'b1;
        bus.alb_vo = 1'b1;
      end
      default: begin
        m_sum = {1'b0, m_b_q} + {1'b0, ~m_a_q} + {{DW{1'b0}}, m_ci_q};
        m_f = m_sum[DW-1:0];
        bus.alb_co = m_sum[DW];
        bus.alb_vo = (m_b_q[DW-1] != m_a_q[DW-1]) && (m_f[DW-1] != m_b_q[DW-1]);
      end
    endcase
    bus.alb_f  = m_f;
    bus.alb_no = m_f[DW-1];
    bus.alb_zo = (m_f == '0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation (res_ready as currently driven) and checks it up to
  // and including the first res_valid cycle.
  task automatic run_op(input vec_t v, input string tag);
    int   cyc;
    logic ci_bad, i_bad, rdy_bad;
    bus.op    = v.op;
    bus.opa   = v.opa;
    bus.opb   = v.opb;
    bus.cin   = v.cin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0; ci_bad = 1'b0; i_bad = 1'b0; rdy_bad = 1'b0;
    while (bus.res_valid !== 1'b1 && cyc < 20) begin
      if (!v.op[0] && bus.alb_ci !== 1'b0) ci_bad = 1'b1;
      if (bus.alb_i !== v.op) i_bad = 1'b1;
      if (bus.ready !== 1'b0) rdy_bad = 1'b1;
      tick();
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'd4);
    check({tag, " res"}, 64'(bus.res), 64'(v.res));
    check({tag, " co/vo/no/zo"}, 64'({bus.res_co, bus.res_vo, bus.res_no, bus.res_zo}),
          64'({v.co, v.vo, v.no, v.zo}));
    check({tag, " alb_ci zero for bitwise op"}, 64'(ci_bad), 64'd0);
    check({tag, " alb_i tracks op"}, 64'({i_bad, bus.alb_i}), 64'({1'b0, v.op}));
    check({tag, " ready low while busy"}, 64'({rdy_bad, bus.ready}), 64'd0);
  endtask

  initial begin
    vec_t v;
    logic second;
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{2'b01, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{2'b01, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{2'b11, 32'h00000005, 32'h00000006, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{2'b11, 32'h00000100, 32'h00000001, 1'b1, 32'h000000FF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 32'hF0F0F0F0, 32'hFFFF0000, 1'b0, 32'h0F0F0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'b00, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{2'b00, 32'h12345678, 32'h80000000, 1'b1, 32'h92345678, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{2'b11, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{2'b11, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};

    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.opa       = '0;
    bus.opb       = '0;
    bus.cin       = 1'b0;
    bus.res_ready = 1'b1;
    #3;
    check("reset ready/valid", 64'({bus.ready, bus.res_valid}), 64'b10);
    check("reset res", 64'(bus.res), 64'd0);
    check("reset flags", 64'({bus.res_co, bus.res_vo, bus.res_no, bus.res_zo}), 64'd0);
    check("reset alb outputs", 64'({bus.alb_a, bus.alb_b, bus.alb_ci, bus.alb_i}), 64'd0);
    tick();
    tick();
    reset = 1'b1;

    // Table: res_ready held high, so res_valid must last exactly one cycle
    for (int i = 0; i < NV; i++) begin
      check($sformatf("v%0d ready before start", i), 64'(bus.ready), 64'd1);
      run_op(vecs[i], $sformatf("v%0d", i));
      tick();
      check($sformatf("v%0d valid one cycle", i), 64'({bus.res_valid, bus.ready}), 64'b01);
      check($sformatf("v%0d idle slice drive", i), 64'({bus.alb_a, bus.alb_b, bus.alb_ci}), 64'd0);
      check($sformatf("v%0d alb_i holds", i), 64'(bus.alb_i), 64'(vecs[i].op));
    end

    // DONE back-pressure, with start pulsed during RUN
    bus.res_ready = 1'b0;
    v = vecs[4];
    bus.op = v.op; bus.opa = v.opa; bus.opb = v.opb; bus.cin = v.cin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.opa   = 32'hDEADBEEF;
    bus.opb   = 32'h01234567;
    bus.cin   = 1'b0;
    tick();
    tick();
    bus.start = 1'b0;
    tick();
    check("bp first valid", 64'({bus.res_valid, bus.ready}), 64'b10);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp hold%0d res", c), 64'(bus.res), 64'(v.res));
      check($sformatf("bp hold%0d flags", c),
            64'({bus.res_co, bus.res_vo, bus.res_no, bus.res_zo}), 64'({v.co, v.vo, v.no, v.zo}));
      check($sformatf("bp hold%0d valid/ready", c), 64'({bus.res_valid, bus.ready}), 64'b10);
    end
    bus.res_ready = 1'b1;
    #1;
    check("bp valid before release edge", 64'(bus.res_valid), 64'd1);
    tick();
    check("bp back to idle", 64'({bus.res_valid, bus.ready}), 64'b01);
    second = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.res_valid !== 1'b0 || bus.ready !== 1'b1) second = 1'b1;
      tick();
    end
    check("bp no second result", 64'(second), 64'd0);

    // Reset asserted in RUN with k=1
    v = vecs[1];
    bus.op = v.op; bus.opa = v.opa; bus.opb = v.opb; bus.cin = v.cin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("abort pre-reset busy", 64'({bus.res_valid, bus.ready}), 64'b00);
    reset = 1'b0;
    #1;
    check("abort ready/valid", 64'({bus.ready, bus.res_valid}), 64'b10);
    check("abort res", 64'(bus.res), 64'd0);
    check("abort flags", 64'({bus.res_co, bus.res_vo, bus.res_no, bus.res_zo}), 64'd0);
    check("abort alb outputs", 64'({bus.alb_a, bus.alb_b, bus.alb_ci, bus.alb_i}), 64'd0);
    tick();
    tick();
    check("abort no result in reset", 64'(bus.res_valid), 64'd0);
    reset = 1'b1;
    run_op(vecs[0], "post-abort");
    tick();
    check("post-abort idle", 64'({bus.res_valid, bus.ready}), 64'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alb_mw_ctrl.md
ALB_MW_CTRL -- requirements
Module: alb_mw_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the slice width of the attached ALB.
REQ-002 The block SHALL have parameter NUM_WORDS, default 4, meaning the number of slices per operation (at least 2).
REQ-003 Let OW = DATA_WIDTH*NUM_WORDS; the block SHALL have one clock and an asynchronous, active-low reset, with the following ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request to start an operation.
- ready  out  1  high only in IDLE.
- op  in  2  00 B|A, 01 B+A+CI, 10 ~B&A, 11 B-A-1+CI.
- opa  in  OW  operand A.
- opb  in  OW  operand B.
- cin  in  1  carry-in to word 0.
- alb_a  out  DATA_WIDTH  A slice to the ALB.
- alb_b  out  DATA_WIDTH  B slice to the ALB.
- alb_ci  out  1  carry to the ALB.
- alb_i  out  2  opcode to the ALB.
- alb_f  in  DATA_WIDTH  ALB result.
- alb_co  in  1  ALB carry flag.
- alb_vo  in  1  ALB overflow flag.
- alb_no  in  1  ALB negative flag.
- alb_zo  in  1  ALB zero flag.
- res  out  OW  full-width result.
- res_co  out  1  final carry.
- res_vo  out  1  final overflow.
- res_no  out  1  final negative.
- res_zo  out  1  final zero.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.

Function
REQ-004 The ALB timing contract SHALL be as follows: alb_a, alb_b and alb_ci are registered inside the ALB at a clk edge; alb_i is used combinationally; alb_f and the flags are valid in the cycle after that edge.
REQ-005 The FSM SHALL have the states IDLE, ISSUE, RUN and DONE.
REQ-006 In IDLE with start=1, the block SHALL latch op, opa, opb and cin at the edge, clear the word index to 0, and move to ISSUE.
REQ-007 start SHALL be ignored outside IDLE.
REQ-008 In ISSUE the block SHALL drive word 0 (bits DATA_WIDTH-1:0) on alb_a/alb_b with alb_ci=latched cin, then move to RUN.
REQ-009 In RUN with index k, the block SHALL capture alb_f into res word k and drive word k+1 with alb_ci=alb_co, combinationally passing the previous slice's carry.
REQ-010 At k=NUM_WORDS-1 the block SHALL capture the last word and flags, set res_valid, and move to DONE.
REQ-011 alb_i SHALL equal the latched op from ISSUE through the last capture cycle.
REQ-012 For op 01 and 11, alb_co SHALL be chained unmodified, since the ALB's subtract carry is active-high no-borrow.
REQ-013 For op 00 and 10, alb_ci SHALL be 0 for every word.
REQ-014 res_co, res_vo and res_no SHALL equal alb_co, alb_vo and alb_no of the last word.
REQ-015 res_zo SHALL be the AND of alb_zo across all words.
REQ-016 For op 00 and 10, res_co and res_vo SHALL be 0.
REQ-017 Latency SHALL be exactly NUM_WORDS cycles from the accepting edge to res_valid=1 (4 at the defaults).
REQ-018 In DONE, res_valid and all res* outputs SHALL hold stable until a cycle with res_ready=1, after which the block SHALL return to IDLE at the next edge.
REQ-019 ready SHALL be 0 from the accepting edge until the return to IDLE.
REQ-020 When res_ready is held at 1 in DONE, res_valid SHALL be high for exactly one cycle.
REQ-021 The next start SHALL be accepted no earlier than the first IDLE cycle.
REQ-022 Outside ISSUE and RUN, alb_a, alb_b and alb_ci SHALL be 0 and alb_i SHALL hold its last value.

Reset
REQ-023 While reset=0, the block SHALL be in IDLE with ready=1, res_valid=0, and res, all res flags, alb_a, alb_b, alb_ci, alb_i and the word index all 0.
REQ-024 Reset assertion mid-operation SHALL abort the operation immediately and asynchronously, with no result produced.
REQ-025 On the first edge after reset release, the block SHALL accept start.

Verification
REQ-026 (defaults) Bench scenario: op=01, opb=0x000000FF, opa=0x00000001, cin=0 -> res=0x00000100, co=0, vo=0, no=0, zo=0, res_valid exactly 4 cycles after accept.
REQ-027 Bench scenario: op=01, opb=0xFFFFFFFF, opa=0x00000001, cin=0 -> res=0x00000000, co=1, zo=1, vo=0; and op=01, opb=0x7FFFFFFF, opa=0x00000001, cin=0 -> res=0x80000000, vo=1, no=1, co=0.
REQ-028 Bench scenario: op=11, opb=0x00000005, opa=0x00000006, cin=1 -> res=0xFFFFFFFF, co=0, no=1, vo=0; and op=11, opb=0x00000100, opa=0x00000001, cin=1 -> res=0x000000FF, co=1, zo=0.
REQ-029 Bench scenario: op=10, opb=0xF0F0F0F0, opa=0xFFFF0000 -> res=0x0F0F0000, co=0, vo=0; and op=00 with both operands 0 -> res=0, zo=1.
REQ-030 Bench scenario: res_ready held 0 for 5 cycles in DONE -> res* stable and ready=0 throughout; start pulses during RUN -> ignored, no second result.
REQ-031 Bench scenario: reset=0 asserted in RUN at k=1 -> outputs go to reset values immediately; a new op=01 issued after release -> correct result, no residue from the aborted operation.
